// File: rtl/nco_ctrl_pkg.sv
// Shared widths and sweep state type for the NCO sweep controller.
package nco_ctrl_pkg;

    localparam int unsigned NCO_FW = 32;
    localparam int unsigned NCO_DW = 16;

    typedef enum logic [1:0] {
        SWEEP_IDLE = 2'd0,
        SWEEP_UP   = 2'd1,
        SWEEP_DOWN = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/nco_sweep_ctrl_dwell_timer.sv
// Dwell counter for the sweep controller: load, count down while enabled, flag count==1.
module dwell_timer #(
    parameter int unsigned DW = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          load_i,
    input  logic [DW-1:0] load_val_i,
    input  logic          en_i,
    output logic          last_o
);

    logic [DW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - DW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == DW'(1));

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving the NCO frequency step.
// Define NCO_SWEEP_BIDIR_EN for a continuous up/down triangle sweep.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int unsigned FW = NCO_FW,
    parameter int unsigned DW = NCO_DW
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [FW-1:0] f_start_i,
    input  logic [FW-1:0] f_stop_i,
    input  logic [FW-1:0] f_inc_i,
    input  logic [DW-1:0] dwell_i,
    output logic [FW-1:0] freq_step_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [1:0] ST_IDLE = 2'(SWEEP_IDLE);
    localparam logic [1:0] ST_UP   = 2'(SWEEP_UP);
`ifdef NCO_SWEEP_BIDIR_EN
    localparam logic [1:0] ST_DOWN = 2'(SWEEP_DOWN);
`endif

    logic [1:0]    state_q, state_d;
    logic [FW-1:0] freq_q, freq_d;
    logic [FW-1:0] fstart_q, fstart_d;
    logic [FW-1:0] fstop_q, fstop_d;
    logic [FW-1:0] finc_q, finc_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          done_q, done_d;

    logic          tmr_load;
    logic [DW-1:0] tmr_val;
    logic          tmr_last;
    logic          busy;
    logic          degen;
    logic [FW:0]   sum;
    logic [FW-1:0] add_val;
`ifdef NCO_SWEEP_BIDIR_EN
    logic [FW:0]   diff;
    logic [FW-1:0] sub_val;
`endif

    assign busy  = (state_q != ST_IDLE);
    assign degen = (finc_q == '0) || (fstart_q >= fstop_q);

    // Extra carry bit so an increment past 2^FW clamps instead of wrapping.
    assign sum     = {1'b0, freq_q} + {1'b0, finc_q};
    assign add_val = (sum >= {1'b0, fstop_q}) ? fstop_q : sum[FW-1:0];
`ifdef NCO_SWEEP_BIDIR_EN
    assign diff    = {1'b0, freq_q} - {1'b0, finc_q};
    assign sub_val = (diff[FW] || (diff[FW-1:0] <= fstart_q)) ? fstart_q : diff[FW-1:0];
`endif

    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        fstart_d = fstart_q;
        fstop_d  = fstop_q;
        finc_d   = finc_q;
        dwell_d  = dwell_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = dwell_q;

        if (state_q == ST_IDLE) begin
            if (start_i && !abort_i) begin
                fstart_d = f_start_i;
                fstop_d  = f_stop_i;
                finc_d   = f_inc_i;
                dwell_d  = (dwell_i == '0) ? DW'(1) : dwell_i;
                freq_d   = f_start_i;
                tmr_load = 1'b1;
                tmr_val  = dwell_d;
                state_d  = ST_UP;
            end
        end else if (abort_i) begin
            state_d  = ST_IDLE;
            freq_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = '0;
        end else if (tmr_last) begin
            tmr_load = 1'b1;
            if (state_q == ST_UP) begin
                if (degen) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    tmr_load = 1'b0;
                end else if (freq_q == fstop_q) begin
`ifdef NCO_SWEEP_BIDIR_EN
                    state_d = ST_DOWN;
                    freq_d  = sub_val;
`else
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    tmr_load = 1'b0;
`endif
                end else begin
                    freq_d = add_val;
                end
            end
`ifdef NCO_SWEEP_BIDIR_EN
            else if (state_q == ST_DOWN) begin
                if (freq_q == fstart_q) begin
                    state_d = ST_UP;
                    freq_d  = add_val;
                end else begin
                    freq_d = sub_val;
                end
            end
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            freq_q   <= '0;
            fstart_q <= '0;
            fstop_q  <= '0;
            finc_q   <= '0;
            dwell_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            fstart_q <= fstart_d;
            fstop_q  <= fstop_d;
            finc_q   <= finc_d;
            dwell_q  <= dwell_d;
            done_q   <= done_d;
        end
    end

    dwell_timer #(
        .DW(DW)
    ) u_dwell_timer (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (busy),
        .last_o     (tmr_last)
    );

    assign freq_step_o = freq_q;
    assign busy_o      = busy;
    assign done_o      = done_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl against a level-list sweep model.
module tb_nco_sweep_ctrl;

    localparam int unsigned FW = 32;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [FW-1:0] fs = '0;
    logic [FW-1:0] fe = '0;
    logic [FW-1:0] fi = '0;
    logic [DW-1:0] dw = '0;
    logic [FW-1:0] freq;
    logic          busy;
    logic          done;

    int            checks = 0;
    int            errors = 0;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] last_freq = '0;

    always #5 clk = ~clk;

    nco_sweep_ctrl #(
        .FW(FW),
        .DW(DW)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .f_start_i   (fs),
        .f_stop_i    (fe),
        .f_inc_i     (fi),
        .dwell_i     (dw),
        .freq_step_o (freq),
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle expected frequency: list of levels, each repeated max(dwell,1) times.
    task automatic build_model(input longint unsigned s, input longint unsigned e,
                               input longint unsigned i, input int unsigned d);
        int unsigned     hold;
        longint unsigned f;
        exp_q.delete();
        hold = (d == 0) ? 1 : d;
        f = s;
        if (i == 0 || s >= e) begin
            repeat (hold) exp_q.push_back(FW'(s));
            return;
        end
        while (1) begin
            repeat (hold) exp_q.push_back(FW'(f));
            if (f == e) break;
            f = (f + i >= e) ? e : f + i;
        end
    endtask

    // Starts a sweep in the current cycle and checks it through the done cycle.
    task automatic run_sweep(input string name, input logic [FW-1:0] s, input logic [FW-1:0] e,
                             input logic [FW-1:0] i, input logic [DW-1:0] d,
                             input bit noisy, input bit chain);
        build_model(s, e, i, d);
        fs = s; fe = e; fi = i; dw = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (freq !== exp_q[k] || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s cycle %0d: freq=%h busy=%b done=%b, want freq=%h busy=1 done=0",
                         name, k + 1, freq, busy, done, exp_q[k]);
            end
            if (noisy) begin
                fs = $urandom; fe = $urandom; fi = $urandom; dw = DW'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            tick();
        end
        start = 1'b0;
        last_freq = exp_q[exp_q.size() - 1];
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || freq !== last_freq) begin
            errors++;
            $display("FAIL %s done cycle: freq=%h busy=%b done=%b, want freq=%h busy=0 done=1",
                     name, freq, busy, done, last_freq);
        end
        if (!chain) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || freq !== last_freq) begin
                errors++;
                $display("FAIL %s hold: freq=%h busy=%b done=%b, want freq=%h busy=0 done=0",
                         name, freq, busy, done, last_freq);
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (freq !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: freq=%h busy=%b done=%b, want all zero", freq, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        fs = 32'd50; fe = 32'd90; fi = 32'd10; dw = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (freq !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: freq=%h busy=%b done=%b, want all zero", freq, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (freq !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid idle: freq=%h busy=%b, want freq=0 busy=0", freq, busy);
        end
    endtask

    task automatic test_abort();
        build_model(100, 400, 100, 3);
        fs = 32'd100; fe = 32'd400; fi = 32'd100; dw = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (freq !== exp_q[c - 1] || busy !== 1'b1) begin
                errors++;
                $display("FAIL abort pre cycle %0d: freq=%h busy=%b, want freq=%h busy=1",
                         c, freq, busy, exp_q[c - 1]);
            end
            if (c == 5) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        checks++;
        if (freq !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort cycle 6: freq=%h busy=%b done=%b, want all zero", freq, busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort cycle 7: busy=%b done=%b, want 0 0", busy, done);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (freq !== 32'd100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort restart: freq=%h busy=%b, want freq=64 busy=1", freq, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        last_freq = '0;
    endtask

    task automatic test_start_abort();
        fs = 32'd7; fe = 32'd70; fi = 32'd7; dw = 16'd1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || freq !== last_freq) begin
                errors++;
                $display("FAIL start_abort cycle %0d: freq=%h busy=%b done=%b, want freq=%h 0 0",
                         c, freq, busy, done, last_freq);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        run_sweep("b2b_a", 32'd10, 32'd30, 32'd10, 16'd1, 1'b0, 1'b1);
        run_sweep("b2b_b", 32'd500, 32'd520, 32'd7, 16'd2, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [FW-1:0] s, e, i;
        logic [DW-1:0] d;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                s = 32'hFFFF_F000 + FW'($urandom_range(0, 32'h800));
                e = 32'hFFFF_FFFF - FW'($urandom_range(0, 32'h400));
                i = FW'($urandom_range(32'h100, 32'h1000));
            end else begin
                s = FW'($urandom_range(0, 400));
                e = FW'($urandom_range(0, 400));
                i = FW'($urandom_range(0, 100));
            end
            d = DW'($urandom_range(0, 4));
            run_sweep("random", s, e, i, d, 1'b1, 1'($urandom_range(0, 1)));
        end
        tick();
    endtask

`ifdef NCO_SWEEP_BIDIR_EN
    task automatic test_bidir();
        longint unsigned f;
        bit              up;
        fs = 32'd100; fe = 32'd400; fi = 32'd100; dw = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        f = 100;
        up = 1'b1;
        for (int c = 0; c < 14; c++) begin
            checks++;
            if (freq !== FW'(f) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL bidir cycle %0d: freq=%h busy=%b done=%b, want freq=%h busy=1 done=0",
                         c, freq, busy, done, FW'(f));
            end
            if (up) begin
                if (f == 400) begin up = 1'b0; f = (f < 200) ? 100 : f - 100; end
                else f = (f + 100 >= 400) ? 400 : f + 100;
            end else begin
                if (f == 100) begin up = 1'b1; f = (f + 100 >= 400) ? 400 : f + 100; end
                else f = (f < 200) ? 100 : f - 100;
            end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (freq !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL bidir abort: freq=%h busy=%b done=%b, want all zero", freq, busy, done);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef NCO_SWEEP_BIDIR_EN
        test_bidir();
`else
        run_sweep("basic", 32'd100, 32'd400, 32'd100, 16'd3, 1'b0, 1'b0);
        run_sweep("clamp", 32'd100, 32'd400, 32'd150, 16'd3, 1'b0, 1'b0);
        run_sweep("overflow", 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 16'd1, 1'b0, 1'b0);
        run_sweep("degen_inc0", 32'd100, 32'd400, 32'd0, 16'd0, 1'b0, 1'b0);
        run_sweep("degen_order", 32'd500, 32'd400, 32'd50, 16'd2, 1'b0, 1'b0);
        test_start_abort();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
                 checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep sequencer for the NCO phase accumulator. Latches a sweep configuration on a start pulse, then drives the NCO's frequency step through a linear ramp from a start word to a stop word, holding each value for a programmable dwell. It sits between the switch/host configuration logic and the NCO's `freq_step` input, replacing the static switch-derived step with a scheduled chirp.

## Interface
- `FW`, 32: frequency-word width; matches the NCO phase accumulator.
- `DW`, 16: dwell-counter width.

- `sys_clk`  in  1  system clock. Reset `sys_rst_n` is asynchronous, active-low; clock is `sys_clk`.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle sweep request; sampled only in IDLE.
- `abort`  in  1  terminate the sweep; takes effect on the next edge.
- `f_start`  in  FW  first frequency word (unsigned).
- `f_stop`  in  FW  final frequency word (unsigned).
- `f_inc`  in  FW  increment per step (unsigned).
- `dwell`  in  DW  cycles spent at each frequency; 0 is treated as 1.
- `freq_step`  out  FW  registered frequency word to the NCO.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  one-cycle pulse when a sweep completes normally.

## Operation
- States: IDLE, UP, DOWN. DOWN exists only with the macro enabled.
- In IDLE, `start`=1 and `abort`=0:
  - latch `f_start`, `f_stop`, `f_inc` and `dwell`;
  - load `freq_step`←`f_start` and the dwell counter←max(`dwell`,1);
  - enter UP.
- Configuration inputs are ignored after the latch. `start` outside IDLE is ignored.
- In UP, the counter decrements every cycle. On the last cycle of a dwell (counter==1):
  - Compute `sum` = `freq_step` + `f_inc` in FW+1 bits. This catches overflow.
  - If `freq_step`==`f_stop`, the sweep ends: go to IDLE, pulse `done`, and hold `freq_step` at `f_stop`.
  - Else if `sum` ≥ `f_stop`: `freq_step`←`f_stop` (clamp).
  - Else: `freq_step`←`sum[FW-1:0]`.
  - Reload the counter.
- Degenerate cases, where `f_inc`==0 or `f_start`≥`f_stop`: one dwell at `f_start`, then `done`. The stop word is not emitted.
- `abort` in UP or DOWN: go to IDLE and set `freq_step`←0. No `done` pulse.
- `abort` and `start` in the same IDLE cycle: abort wins and the start is dropped.
- `busy` = (state != IDLE).
- Reset, including mid-sweep: state IDLE, `freq_step`=0, `busy`=0, `done`=0, counter=0, latched configuration=0.

## Timing
- `start` is sampled at edge N. At edge N+1, `freq_step`=`f_start` and `busy`=1.
- Each frequency value is held exactly max(`dwell`,1) cycles. No extra step cycle.
- `done` rises in the same cycle `busy` falls. `done` is high for one cycle.
- A new `start` is accepted in the cycle `done` is high, since the block is already in IDLE.
- The abort response is visible one cycle after `abort` is sampled.

## Configuration
- Macro `NCO_SWEEP_BIDIR_EN`.
- Defined: when UP reaches `f_stop`, enter DOWN after its dwell.
  - DOWN subtracts `f_inc`, clamping to `f_start` on borrow or undershoot.
  - Reaching `f_start` and completing its dwell re-enters UP.
  - The result is a continuous triangle sweep. `done` never pulses; only `abort` exits.
- Undefined: single upward sweep as above. The DOWN state and subtractor are not synthesised.

## Structure
- Package `nco_ctrl_pkg`:
  - state enum `sweep_state_t` (IDLE/UP/DOWN);
  - default widths `NCO_FW`=32 and `NCO_DW`=16.
- One sub-module: `dwell_timer`. It holds the load/decrement counter and outputs `last` when count==1. Its inputs are `load`, `load_val`, `en`.
- The clamped add and subtract logic stays in the top level.

## Test plan
- Basic ramp: `f_start`=100, `f_stop`=400, `f_inc`=100, `dwell`=3, `start` at cycle 0.
  - `freq_step` = 100 in cycles 1–3, 200 in 4–6, 300 in 7–9, 400 in 10–12.
  - `done`=1 and `busy`=0 in cycle 13, then `freq_step` holds 400.
- Clamp: `f_inc`=150, other settings as above → sequence 100, 250, 400, then `done`.
- Overflow: `f_start`=0xFFFF_FF00, `f_stop`=0xFFFF_FFFF, `f_inc`=0x200, `dwell`=1 → 0xFFFF_FF00, then 0xFFFF_FFFF, then `done`. No wrap to a small value.
- Abort: basic ramp with `abort` at cycle 5 → `freq_step`=0 and `busy`=0 in cycle 6. No `done`. A `start` at cycle 8 restarts from 100.
- Degenerate: `f_inc`=0, `dwell`=0 → `f_start` for 1 cycle, then `done`. Separately, `start` and `abort` together in IDLE → `busy` stays 0.
- Bidirectional (`NCO_SWEEP_BIDIR_EN`): basic ramp with `dwell`=1 → 100, 200, 300, 400, 300, 200, 100, 200 … No `done`. `abort` returns to IDLE.
